// File: rtl/prog_loader.sv
// prog_loader: writer side of the TD4 instruction memory.
// Receives a 16-byte program plus a trailing checksum byte over a valid/ready stream,
// fills a 16x8 RAM and releases the CPU core only after the checksum verifies.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   load_start  single-cycle request to begin/restart a load (wins over a same-cycle transfer)
//   in_data     stream byte, in_valid qualifies it, in_ready shows acceptance
//   cpu_addr    CPU fetch address; cpu_data is mem[cpu_addr], combinational
//   cpu_run     active-low reset to the core (1 only in RUN)
//   busy        loading or waiting for the checksum
//   done        one-cycle pulse after a good checksum
//   err         sticky checksum-failure flag, cleared by load_start
//   wcount      bytes written in the current load, 0..16
module prog_loader #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] cpu_addr,
  output logic [DW-1:0] cpu_data,
  output logic          cpu_run,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   wcount
);

  localparam int unsigned Depth = 1 << AW;

  typedef enum logic [2:0] {StIdle, StLoad, StCheck, StRun, StErr} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [DW-1:0] sum_q, sum_d;
  logic [AW:0]   wcount_q, wcount_d;
  logic          in_ready_q, in_ready_d;
  logic          cpu_run_q, cpu_run_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [DW-1:0] mem_q [Depth];
  logic [DW-1:0] mem_d [Depth];

  logic          xfer;
  logic [DW-1:0] sum_next;

  assign xfer     = in_valid & in_ready_q;
  assign sum_next = sum_q + in_data;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    sum_d    = sum_q;
    wcount_d = wcount_q;
    mem_d    = mem_q;
    done_d   = 1'b0;

    if (load_start) begin
      // Restart from any state; a transfer in the same cycle is dropped.
      state_d  = StLoad;
      wptr_d   = '0;
      sum_d    = '0;
      wcount_d = '0;
    end else begin
      case (state_q)
        StLoad: begin
          if (xfer) begin
            mem_d[wptr_q] = in_data;
            wptr_d        = wptr_q + AW'(1);
            sum_d         = sum_next;
            wcount_d      = wcount_q + (AW + 1)'(1);
            if (wptr_q == '1) begin
              state_d = StCheck;
            end
          end
        end
        StCheck: begin
          // Checksum byte: wcount is left at 16.
          if (xfer) begin
            if (sum_next == '0) begin
              state_d = StRun;
              done_d  = 1'b1;
            end else begin
              state_d = StErr;
            end
          end
        end
        default: ;
      endcase
    end

    in_ready_d = (state_d == StLoad) || (state_d == StCheck);
    cpu_run_d  = (state_d == StRun);
    err_d      = (state_d == StErr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      sum_q      <= '0;
      wcount_q   <= '0;
      in_ready_q <= 1'b0;
      cpu_run_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      sum_q      <= sum_d;
      wcount_q   <= wcount_d;
      in_ready_q <= in_ready_d;
      cpu_run_q  <= cpu_run_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mem_q      <= mem_d;
    end
  end

  assign cpu_data = mem_q[cpu_addr];
  assign in_ready = in_ready_q;
  assign cpu_run  = cpu_run_q;
  assign busy     = (state_q == StLoad) || (state_q == StCheck);
  assign done     = done_q;
  assign err      = err_q;
  assign wcount   = wcount_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: randomized streams compared every cycle against a
// queue-based model of a program load (bytes received so far, checksum over the queue).
module tb_prog_loader;

  logic       clk;
  logic       reset;
  logic       load_start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_data;
  logic       cpu_run;
  logic       busy;
  logic       done;
  logic       err;
  logic [4:0] wcount;

  prog_loader #(
    .AW(4),
    .DW(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_start(load_start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_run   (cpu_run),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .wcount    (wcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int PIdle  = 0;
  localparam int PLoad  = 1;
  localparam int PCheck = 2;
  localparam int PRun   = 3;
  localparam int PErr   = 4;

  int         n_total = 0;
  int         n_bad   = 0;

  // Reference model
  int         m_phase;
  logic [7:0] m_rx[$];
  logic [7:0] m_mem[16];
  bit         m_done;

  logic [7:0] img[16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rx_sum();
    int s = 0;
    foreach (m_rx[i]) s += int'(m_rx[i]);
    return s;
  endfunction

  task automatic model_reset();
    m_phase = PIdle;
    m_rx.delete();
    m_done = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
  endtask

  task automatic model_edge(input logic ls, input logic v, input logic [7:0] d);
    m_done = 1'b0;
    if (ls) begin
      m_phase = PLoad;
      m_rx.delete();
    end else if (v && m_phase == PLoad) begin
      m_mem[m_rx.size()] = d;
      m_rx.push_back(d);
      if (m_rx.size() == 16) m_phase = PCheck;
    end else if (v && m_phase == PCheck) begin
      if (((rx_sum() + int'(d)) % 256) == 0) begin
        m_phase = PRun;
        m_done  = 1'b1;
      end else begin
        m_phase = PErr;
      end
    end
  endtask

  task automatic check_all();
    logic ld;
    ld = (m_phase == PLoad) || (m_phase == PCheck);
    check_eq("in_ready", 32'(in_ready), 32'(ld));
    check_eq("busy", 32'(busy), 32'(ld));
    check_eq("cpu_run", 32'(cpu_run), 32'(m_phase == PRun));
    check_eq("err", 32'(err), 32'(m_phase == PErr));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("wcount", 32'(wcount), 32'(m_rx.size()));
    check_eq("cpu_data", 32'(cpu_data), 32'(m_mem[cpu_addr]));
  endtask

  // One clock: drive at negedge, update model at posedge, compare 1 ns later.
  task automatic cyc(input logic ls, input logic v, input logic [7:0] d);
    @(negedge clk);
    load_start = ls;
    in_valid   = v;
    in_data    = d;
    cpu_addr   = 4'($urandom_range(0, 15));
    @(posedge clk);
    model_edge(ls, v, d);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] b, input int maxgap);
    int g;
    g = (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
    repeat (g) cyc(1'b0, 1'b0, 8'($urandom));
    cyc(1'b0, 1'b1, b);
  endtask

  task automatic load_image(input bit start, input bit good, input int maxgap);
    int         s;
    logic [7:0] chk;
    s = 0;
    for (int i = 0; i < 16; i++) s += int'(img[i]);
    chk = 8'((256 - (s % 256)) % 256);
    if (!good) chk = chk + 8'd1;
    if (start) cyc(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 16; i++) send(img[i], maxgap);
    send(chk, maxgap);
  endtask

  task automatic read_back(input string tag);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      load_start = 1'b0;
      in_valid   = 1'b0;
      cpu_addr   = 4'(a);
      #1;
      check_eq(tag, 32'(cpu_data), 32'(img[a]));
    end
  endtask

  task automatic rand_img();
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
  endtask

  initial begin
    reset      = 1'b0;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    cpu_addr   = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Valid data while idle is ignored.
    repeat (4) cyc(1'b0, 1'b1, 8'($urandom));

    // 1: good load, fixed pattern, no gaps.
    for (int i = 0; i < 16; i++) img[i] = 8'(8'h31 + i * 8'h21);
    load_image(1'b1, 1'b1, 0);
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_run", 32'(cpu_run), 32'd1);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("t1_done_once", 32'(done), 32'd0);
    check_eq("t1_run_hold", 32'(cpu_run), 32'd1);
    read_back("t1_read");

    // 2: bad checksum, err stays until the next load_start.
    load_image(1'b1, 1'b0, 0);
    repeat (3) cyc(1'b0, 1'b1, 8'($urandom));
    check_eq("t2_err", 32'(err), 32'd1);
    check_eq("t2_run", 32'(cpu_run), 32'd0);
    cyc(1'b1, 1'b0, 8'h00);
    check_eq("t2_err_clr", 32'(err), 32'd0);

    // 3: random gaps, random image.
    rand_img();
    load_image(1'b1, 1'b1, 5);
    read_back("t3_read");

    // 4: restart after 7 bytes with a colliding transfer of 8'hAA.
    rand_img();
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) send(img[i], 2);
    cyc(1'b1, 1'b1, 8'hAA);
    check_eq("t4_wcount", 32'(wcount), 32'd0);
    check_eq("t4_ready", 32'(in_ready), 32'd1);
    rand_img();
    load_image(1'b0, 1'b1, 3);
    read_back("t4_read");

    // 6: reload from RUN.
    rand_img();
    cyc(1'b1, 1'b0, 8'h00);
    check_eq("t6_run_fall", 32'(cpu_run), 32'd0);
    load_image(1'b0, 1'b1, 2);
    check_eq("t6_run_rise", 32'(cpu_run), 32'd1);
    read_back("t6_read");

    // 5: asynchronous reset after 10 bytes.
    rand_img();
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) send(img[i], 1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a);
      #1;
      check_eq("t5_zero", 32'(cpu_data), 32'h0);
    end
    @(negedge clk);
    load_start = 1'b0;
    in_valid   = 1'b0;
    reset      = 1'b1;
    repeat (3) cyc(1'b0, 1'b1, 8'($urandom));
    rand_img();
    load_image(1'b1, 1'b1, 4);
    read_back("t5_reload");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
